// File: rtl/err_sat_diff_pkg.sv
// err_sat_diff_pkg: shared default widths and saturation limit helpers for the error/derivative path
package err_sat_diff_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_ERR_W = 10;
    localparam int DEF_D_W   = 7;
    localparam int SAT_CNT_W = 8;

    // Largest value representable in a w-bit two's-complement word
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative value representable in a w-bit two's-complement word
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/err_sat_diff_sat_signed.sv
// sat_signed: combinational two's-complement clamp from I_W to O_W bits with a clamp-occurred flag
module sat_signed
    import err_sat_diff_pkg::*;
#(
    parameter int I_W = 11,
    parameter int O_W = 7
) (
    input  logic [I_W-1:0] i_d,
    output logic [O_W-1:0] o_q,
    output logic           o_clamp
);

    localparam logic [O_W-1:0] MAX = O_W'(sat_max(O_W));
    localparam logic [O_W-1:0] MIN = O_W'(sat_min(O_W));

    logic [I_W-O_W:0] w_top;

    // The value fits only when every bit from the output sign bit upward agrees
    always_comb begin
        w_top   = i_d[I_W-1:O_W-1];
        o_clamp = (|w_top) & ~(&w_top);
        o_q     = o_clamp ? (i_d[I_W-1] ? MIN : MAX) : i_d[O_W-1:0];
    end

endmodule

// File: rtl/err_sat_diff.sv
// err_sat_diff: saturates a raw error sample, then forms a lagged, saturated derivative with saturation statistics
module err_sat_diff
    import err_sat_diff_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int D_W    = DEF_D_W,
    parameter int QDEPTH = 2,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld,
    input  logic [IN_W-1:0]      err,
    input  logic                 clr,
    output logic [ERR_W-1:0]     err_sat,
    output logic [D_W-1:0]       D_diff_sat,
    output logic                 out_vld,
    output logic [SAT_CNT_W-1:0] sat_cnt,
    output logic                 sat_flag
);

    logic             r_in_vld;
    logic [IN_W-1:0]  r_in;
    logic             r_s1_vld;
    logic             r_s1_cl;
    logic [ERR_W-1:0] r_s1;
    logic [ERR_W-1:0] r_hist [QDEPTH];

    logic [ERR_W-1:0] w_s1_s;
    logic [ERR_W-1:0] w_s1;
    logic             w_s1_s_cl;
    logic             w_s1_u_cl;
    logic             w_s1_cl;
    logic [ERR_W:0]   w_a;
    logic [ERR_W:0]   w_b;
    logic [ERR_W:0]   w_diff;
    logic [D_W-1:0]   w_d;
    logic             w_d_cl;
    logic             w_sat;

    sat_signed #(.I_W(IN_W), .O_W(ERR_W)) u_sat_s1 (
        .i_d     (r_in),
        .o_q     (w_s1_s),
        .o_clamp (w_s1_s_cl)
    );

    sat_signed #(.I_W(ERR_W + 1), .O_W(D_W)) u_sat_s2 (
        .i_d     (w_diff),
        .o_q     (w_d),
        .o_clamp (w_d_cl)
    );

    // Stage-1 clamp selection and the one-bit-wider difference against the oldest history entry
    always_comb begin
        w_s1_u_cl = |r_in[IN_W-1:ERR_W];
        w_s1      = (SIGNED != 0) ? w_s1_s : (w_s1_u_cl ? '1 : r_in[ERR_W-1:0]);
        w_s1_cl   = (SIGNED != 0) ? w_s1_s_cl : w_s1_u_cl;
        w_a       = (SIGNED != 0) ? {r_s1[ERR_W-1], r_s1} : {1'b0, r_s1};
        w_b       = (SIGNED != 0) ? {r_hist[QDEPTH-1][ERR_W-1], r_hist[QDEPTH-1]} : {1'b0, r_hist[QDEPTH-1]};
        w_diff    = w_a - w_b;
        w_sat     = r_s1_cl | w_d_cl;
    end

    // Capture the incoming sample; clr discards a coincident sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld <= 1'b0;
            r_in     <= '0;
        end else begin
            r_in_vld <= vld & ~clr;
            if (vld & ~clr) r_in <= err;
        end
    end

    // Stage 1: register the saturated error and whether it clamped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_cl  <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= r_in_vld & ~clr;
            if (r_in_vld) begin
                r_s1    <= w_s1;
                r_s1_cl <= w_s1_cl;
            end
        end
    end

    // Stage 2: publish outputs, advance history and update saturation statistics per accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld    <= 1'b0;
            err_sat    <= '0;
            D_diff_sat <= '0;
            sat_cnt    <= '0;
            sat_flag   <= 1'b0;
            r_hist     <= '{default: '0};
        end else if (clr) begin
            out_vld  <= 1'b0;
            sat_cnt  <= '0;
            sat_flag <= 1'b0;
            r_hist   <= '{default: '0};
        end else begin
            out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                err_sat    <= r_s1;
                D_diff_sat <= w_d;
                r_hist[0]  <= r_s1;
                for (int i = 1; i < QDEPTH; i++) r_hist[i] <= r_hist[i-1];
                if (w_sat) begin
                    sat_cnt  <= (&sat_cnt) ? sat_cnt : sat_cnt + SAT_CNT_W'(1);
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule
